shift_register_ctr: RTL and testbench



---
 rtl/shift_register_ctr.sv | 96 +++++++++
 tb/tb_shift_register_ctr.sv | 137 +++++++++++++
 2 files changed

// File: rtl/shift_register_ctr.sv
// Parametrised shift/load register with a saturating shift counter and sticky done flag.
// Serves as the partial-remainder/quotient storage of the iterative divider.
module shift_register_ctr #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned STEPS = WIDTH,
  localparam int unsigned CNT_W = $clog2(STEPS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             E,
  input  logic             CLR,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic             SI,
  output logic [WIDTH-1:0] Q,
  output logic             SO,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  localparam logic [CNT_W-1:0] STEPS_C = CNT_W'(STEPS);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_LOAD  = 2'b01;
  localparam logic [1:0] MODE_SHL   = 2'b10;
  localparam logic [1:0] MODE_SHR   = 2'b11;

  logic [WIDTH-1:0] r_q;
  logic             r_so;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;

  logic [WIDTH-1:0] w_q_nxt;
  logic             w_so_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_done_nxt;
  logic [CNT_W-1:0] w_cnt_step;

  // Counter saturates at STEPS so done stays meaningful while shifting continues
  assign w_cnt_step = (r_cnt < STEPS_C) ? r_cnt + CNT_W'(1) : r_cnt;

  always_comb begin
    w_q_nxt    = r_q;
    w_so_nxt   = r_so;
    w_cnt_nxt  = r_cnt;
    w_done_nxt = r_done;
    if (CLR) begin
      w_q_nxt    = '0;
      w_so_nxt   = 1'b0;
      w_cnt_nxt  = '0;
      w_done_nxt = 1'b0;
    end else if (E) begin
      case (mode)
        MODE_HOLD: ;
        MODE_LOAD: begin
          w_q_nxt    = D;
          w_cnt_nxt  = '0;
          w_done_nxt = 1'b0;
        end
        MODE_SHL: begin
          w_q_nxt    = {r_q[WIDTH-2:0], SI};
          w_so_nxt   = r_q[WIDTH-1];
          w_cnt_nxt  = w_cnt_step;
          w_done_nxt = r_done | (w_cnt_step == STEPS_C);
        end
        MODE_SHR: begin
          w_q_nxt    = {SI, r_q[WIDTH-1:1]};
          w_so_nxt   = r_q[0];
          w_cnt_nxt  = w_cnt_step;
          w_done_nxt = r_done | (w_cnt_step == STEPS_C);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q    <= '0;
      r_so   <= 1'b0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      r_so   <= w_so_nxt;
      r_cnt  <= w_cnt_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign Q    = r_q;
  assign SO   = r_so;
  assign cnt  = r_cnt;
  assign done = r_done;

endmodule

// File: tb/tb_shift_register_ctr.sv
// Scoreboard bench for shift_register_ctr (WIDTH=4, STEPS=4): stimulus pushes expected
// state tagged with the cycle it becomes visible; a monitor pops and compares on negedge.
module tb_shift_register_ctr;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned STEPS = 4;
  localparam int unsigned CNT_W = $clog2(STEPS + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             E = 1'b0;
  logic             CLR = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic [WIDTH-1:0] D = '0;
  logic             SI = 1'b0;
  logic [WIDTH-1:0] Q;
  logic             SO;
  logic [CNT_W-1:0] cnt;
  logic             done;

  shift_register_ctr #(.WIDTH(WIDTH), .STEPS(STEPS)) dut (
    .clk(clk), .reset(reset), .E(E), .CLR(CLR), .mode(mode), .D(D), .SI(SI),
    .Q(Q), .SO(SO), .cnt(cnt), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               due;
    string            name;
    logic [WIDTH-1:0] q;
    logic             so;
    logic [CNT_W-1:0] cnt;
    logic             done;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation whose visible cycle has arrived
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        n_tests++;
        if (Q !== e.q || SO !== e.so || cnt !== e.cnt || done !== e.done) begin
          n_fail++;
          $display("FAIL %s: got Q=%b SO=%b cnt=%0d done=%b, expected Q=%b SO=%b cnt=%0d done=%b",
                   e.name, Q, SO, cnt, done, e.q, e.so, e.cnt, e.done);
        end
      end
    end
  end

  task automatic push(input int due, input string name, input logic [WIDTH-1:0] q,
                      input logic so, input int c, input logic d);
    exp_t e;
    e.due = due; e.name = name; e.q = q; e.so = so; e.cnt = CNT_W'(c); e.done = d;
    exp_q.push_back(e);
  endtask

  // Drive one edge's inputs on the negedge and queue the post-edge state
  task automatic step(input logic e_i, input logic clr_i, input logic [1:0] m_i,
                      input logic [WIDTH-1:0] d_i, input logic si_i, input string name,
                      input logic [WIDTH-1:0] q, input logic so, input int c, input logic d);
    @(negedge clk);
    E = e_i; CLR = clr_i; mode = m_i; D = d_i; SI = si_i;
    push(cyc + 1, name, q, so, c, d);
  endtask

  initial begin
    // 1: reset held with clock running, then load
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 2'b01, 4'b0001, 1'b0, "reset_hold", 4'b0000, 1'b0, 0, 1'b0);
    @(negedge clk); reset = 1'b0;
    step(1'b1, 1'b0, 2'b01, 4'b0001, 1'b0, "load_after_reset", 4'b0001, 1'b0, 0, 1'b0);

    // 2: shift left, saturation
    step(1'b1, 1'b0, 2'b01, 4'b1011, 1'b0, "shl_load", 4'b1011, 1'b0, 0, 1'b0);
    step(1'b1, 1'b0, 2'b10, 4'b0000, 1'b0, "shl_1", 4'b0110, 1'b1, 1, 1'b0);
    step(1'b1, 1'b0, 2'b10, 4'b0000, 1'b0, "shl_2", 4'b1100, 1'b0, 2, 1'b0);
    step(1'b1, 1'b0, 2'b10, 4'b0000, 1'b0, "shl_3", 4'b1000, 1'b1, 3, 1'b0);
    step(1'b1, 1'b0, 2'b10, 4'b0000, 1'b0, "shl_4_done", 4'b0000, 1'b1, 4, 1'b1);
    step(1'b1, 1'b0, 2'b10, 4'b0000, 1'b0, "shl_5_sat", 4'b0000, 1'b0, 4, 1'b1);

    // 3: shift right, then load clears done
    step(1'b1, 1'b0, 2'b01, 4'b0001, 1'b0, "shr_load", 4'b0001, 1'b0, 0, 1'b0);
    step(1'b1, 1'b0, 2'b11, 4'b0000, 1'b1, "shr_1", 4'b1000, 1'b1, 1, 1'b0);
    step(1'b1, 1'b0, 2'b11, 4'b0000, 1'b1, "shr_2", 4'b1100, 1'b0, 2, 1'b0);
    step(1'b1, 1'b0, 2'b11, 4'b0000, 1'b1, "shr_3", 4'b1110, 1'b0, 3, 1'b0);
    step(1'b1, 1'b0, 2'b11, 4'b0000, 1'b1, "shr_4_done", 4'b1111, 1'b0, 4, 1'b1);
    step(1'b1, 1'b0, 2'b01, 4'b0101, 1'b0, "load_clears_done", 4'b0101, 1'b0, 0, 1'b0);

    // 4: enable gating
    step(1'b1, 1'b0, 2'b01, 4'b0001, 1'b0, "en_load", 4'b0001, 1'b0, 0, 1'b0);
    step(1'b1, 1'b0, 2'b10, 4'b0000, 1'b0, "en_1", 4'b0010, 1'b0, 1, 1'b0);
    step(1'b0, 1'b0, 2'b10, 4'b0000, 1'b0, "en_0_hold", 4'b0010, 1'b0, 1, 1'b0);
    step(1'b1, 1'b0, 2'b10, 4'b0000, 1'b0, "en_1b", 4'b0100, 1'b0, 2, 1'b0);
    step(1'b0, 1'b0, 2'b10, 4'b0000, 1'b0, "en_0b_hold", 4'b0100, 1'b0, 2, 1'b0);

    // 5: asynchronous reset mid-shift
    step(1'b1, 1'b0, 2'b01, 4'b0011, 1'b0, "ar_load", 4'b0011, 1'b0, 0, 1'b0);
    step(1'b1, 1'b0, 2'b10, 4'b0000, 1'b0, "ar_shl_1", 4'b0110, 1'b0, 1, 1'b0);
    step(1'b1, 1'b0, 2'b10, 4'b0000, 1'b0, "ar_shl_2", 4'b1100, 1'b0, 2, 1'b0);
    @(negedge clk); E = 1'b1; mode = 2'b10;
    @(posedge clk); #2 reset = 1'b1;
    push(cyc, "async_reset", 4'b0000, 1'b0, 0, 1'b0);
    @(negedge clk); reset = 1'b0; E = 1'b1; mode = 2'b01; D = 4'b1010;
    push(cyc + 1, "load_after_async_reset", 4'b1010, 1'b0, 0, 1'b0);

    // 6: CLR priority over E=0 and load
    step(1'b1, 1'b0, 2'b10, 4'b0000, 1'b1, "clr_shl_1", 4'b0101, 1'b1, 1, 1'b0);
    step(1'b1, 1'b0, 2'b10, 4'b0000, 1'b1, "clr_shl_2", 4'b1011, 1'b0, 2, 1'b0);
    step(1'b1, 1'b0, 2'b10, 4'b0000, 1'b1, "clr_shl_3", 4'b0111, 1'b1, 3, 1'b0);
    step(1'b1, 1'b0, 2'b10, 4'b0000, 1'b1, "clr_shl_4", 4'b1111, 1'b0, 4, 1'b1);
    step(1'b1, 1'b0, 2'b11, 4'b0000, 1'b0, "shr_after_done", 4'b0111, 1'b1, 4, 1'b1);
    step(1'b1, 1'b0, 2'b00, 4'b1001, 1'b1, "mode_hold", 4'b0111, 1'b1, 4, 1'b1);
    step(1'b0, 1'b1, 2'b01, 4'b1111, 1'b0, "clr_priority", 4'b0000, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 2'b00, 4'b0000, 1'b0, "idle_after_clr", 4'b0000, 1'b0, 0, 1'b0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
